// File: rtl/chu_spi_slave_core.sv
// rtl/chu_spi_slave_core.sv - SPI peripheral (slave) MMIO slot core, all four CPOL/CPHA modes
module chu_spi_slave_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        spi_miso_en
);
    // sclk and mosi get three stages so mosi stays aligned with the sclk edge detector
    logic [2:0] sclk_sync;
    logic [2:0] mosi_sync;
    logic [1:0] ss_sync;

    logic [2:0] ctrl;
    logic [7:0] tx_buf;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic [7:0] tx_shreg;
    logic [7:0] rx_shreg;
    logic [2:0] bit_cnt;
    logic       ss_active_q;
    logic       act_cpol;
    logic       act_cpha;

    logic ss_active, ss_rise, ss_fall, in_frame;
    logic sclk_rise, sclk_fall, lead, trail;
    logic sample, shift, load_now, complete;
    logic wr_tx, wr_stat, wr_ctrl, pop, ov_clr;
    logic unused_bits;

    assign unused_bits = ^{read, addr[4:2], wr_data[31:8]};

    assign ss_active = ~ss_sync[1] & ctrl[2];
    assign ss_rise   = ss_active & ~ss_active_q;
    assign ss_fall   = ~ss_active & ss_active_q;
    assign in_frame  = ss_active & ss_active_q;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign lead      = act_cpol ? sclk_fall : sclk_rise;
    assign trail     = act_cpol ? sclk_rise : sclk_fall;

    // cpha selects which edge samples mosi and which one advances miso
    assign sample   = in_frame & (act_cpha ? trail : lead);
    assign shift    = in_frame & (act_cpha ? lead : trail);
    assign load_now = (ss_rise & ~ctrl[1]) | (shift & (bit_cnt == 3'd0));
    assign complete = sample & (bit_cnt == 3'd7);

    assign wr_tx   = cs & write & (addr[1:0] == 2'b01);
    assign wr_stat = cs & write & (addr[1:0] == 2'b10);
    assign wr_ctrl = cs & write & (addr[1:0] == 2'b11);
    assign pop     = wr_stat & wr_data[0];
    assign ov_clr  = wr_stat & wr_data[1];

    assign rd_data     = {20'b0, ss_active, overrun, tx_full, rx_valid, rx_data};
    assign spi_miso    = tx_shreg[7];
    assign spi_miso_en = ss_active;

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= 3'b000;
            mosi_sync <= 3'b000;
            ss_sync   <= 2'b11;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk};
            mosi_sync <= {mosi_sync[1:0], spi_mosi};
            ss_sync   <= {ss_sync[0], spi_ss_n};
        end
    end

    // Register file: control, transmit holding buffer and receive status
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= 3'b000;
            tx_buf   <= 8'h00;
            tx_full  <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl <= wr_data[2:0];
            if (wr_tx)
                tx_buf <= wr_data[7:0];
            // a write coinciding with a load still leaves the new byte pending
            if (wr_tx)
                tx_full <= 1'b1;
            else if (load_now)
                tx_full <= 1'b0;
            if (complete)
                rx_data <= {rx_shreg[6:0], mosi_sync[2]};
            // completion beats a simultaneous pop
            if (complete)
                rx_valid <= 1'b1;
            else if (pop)
                rx_valid <= 1'b0;
            if (complete & rx_valid & ~pop)
                overrun <= 1'b1;
            else if (ov_clr)
                overrun <= 1'b0;
        end
    end

    // Frame engine: bit counter, shift registers and per-frame mode latch
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_active_q <= 1'b0;
            act_cpol    <= 1'b0;
            act_cpha    <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_shreg    <= 8'h00;
            tx_shreg    <= 8'hFF;
        end else begin
            ss_active_q <= ss_active;
            if (ss_rise) begin
                act_cpol <= ctrl[0];
                act_cpha <= ctrl[1];
            end
            if (ss_rise | ss_fall)
                bit_cnt <= 3'd0;
            else if (sample)
                bit_cnt <= bit_cnt + 3'd1;
            if (sample)
                rx_shreg <= {rx_shreg[6:0], mosi_sync[2]};
            if (ss_fall)
                tx_shreg <= 8'hFF;
            else if (load_now)
                tx_shreg <= tx_full ? tx_buf : 8'hFF;
            else if (shift)
                tx_shreg <= {tx_shreg[6:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_chu_spi_slave_core.sv
// tb/tb_chu_spi_slave_core.sv - directed bench for chu_spi_slave_core with a bit-banged SPI master
module tb_chu_spi_slave_core;
    logic        clk = 1'b0;
    logic        reset, cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic        spi_sclk, spi_mosi, spi_ss_n, spi_miso, spi_miso_en;

    int   total = 0;
    int   bad = 0;
    bit   m_cpol, m_cpha;
    logic [7:0] r0, r1;

    chu_spi_slave_core dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
        .spi_miso(spi_miso), .spi_miso_en(spi_miso_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
    endtask

    task automatic half(input bit pop_here);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (pop_here && k == 1) begin
                cs = 1'b1; write = 1'b1; addr = 5'd2; wr_data = 32'h1;
            end
            if (pop_here && k == 2) begin
                cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
            end
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit pop_last,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!m_cpha) begin
                spi_mosi = tx[7-i];
                half(1'b0);
                rx[7-i] = spi_miso;
                spi_sclk = ~m_cpol;
                half(pop_last && (i == nbits - 1));
                spi_sclk = m_cpol;
            end else begin
                spi_sclk = ~m_cpol;
                spi_mosi = tx[7-i];
                half(1'b0);
                rx[7-i] = spi_miso;
                spi_sclk = m_cpol;
                half(1'b0);
            end
        end
    endtask

    task automatic ss_low();
        spi_sclk = m_cpol;
        repeat (4) @(posedge clk); #1;
        spi_ss_n = 1'b0;
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic ss_high();
        repeat (4) @(posedge clk); #1;
        spi_ss_n = 1'b1;
        repeat (6) @(posedge clk); #1;
    endtask

    task automatic set_mode(input logic [2:0] c);
        m_cpol = c[0];
        m_cpha = c[1];
        bus_wr(5'd3, {29'd0, c});
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1; m_cpol = 1'b0; m_cpha = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_rd", rd_data, 32'h0);
        chk("rst_miso", {31'd0, spi_miso}, 32'h1);
        chk("rst_miso_en", {31'd0, spi_miso_en}, 32'h0);

        // mode 0 single byte
        set_mode(3'b100);
        bus_wr(5'd1, 32'hA5);
        chk("m0_txfull", rd_data, 32'h200);
        ss_low();
        chk("m0_ss_active", {31'd0, rd_data[11]}, 32'h1);
        chk("m0_miso_en", {31'd0, spi_miso_en}, 32'h1);
        spi_byte(8'h3C, 8, 1'b0, r0);
        ss_high();
        chk("m0_master_rx", {24'd0, r0}, 32'hA5);
        chk("m0_rd", rd_data, 32'h13C);

        // mode 3
        bus_wr(5'd2, 32'h3);
        set_mode(3'b111);
        bus_wr(5'd1, 32'h5A);
        ss_low();
        spi_byte(8'hC3, 8, 1'b0, r0);
        ss_high();
        chk("m3_master_rx", {24'd0, r0}, 32'h5A);
        chk("m3_rd", rd_data, 32'h1C3);

        // mode 1
        bus_wr(5'd2, 32'h3);
        set_mode(3'b110);
        bus_wr(5'd1, 32'h96);
        ss_low();
        spi_byte(8'h69, 8, 1'b0, r0);
        ss_high();
        chk("m1_master_rx", {24'd0, r0}, 32'h96);
        chk("m1_rd", rd_data, 32'h169);

        // mode 2
        bus_wr(5'd2, 32'h3);
        set_mode(3'b101);
        bus_wr(5'd1, 32'h0F);
        ss_low();
        spi_byte(8'hF0, 8, 1'b0, r0);
        ss_high();
        chk("m2_master_rx", {24'd0, r0}, 32'h0F);
        chk("m2_rd", rd_data, 32'h1F0);

        // addr 00 write has no effect
        bus_wr(5'd0, 32'hFFFF_FFFF);
        chk("addr0_ignored", rd_data, 32'h1F0);

        // two bytes in one frame, no pop in between
        bus_wr(5'd2, 32'h3);
        set_mode(3'b100);
        bus_wr(5'd1, 32'h77);
        ss_low();
        spi_byte(8'h12, 8, 1'b0, r0);
        spi_byte(8'h81, 8, 1'b0, r1);
        ss_high();
        chk("two_rx0", {24'd0, r0}, 32'h77);
        chk("two_rx1", {24'd0, r1}, 32'hFF);
        chk("two_rd", rd_data, 32'h581);
        bus_wr(5'd2, 32'h3);
        chk("two_clear", rd_data, 32'h081);

        // aborted byte after 5 bits
        ss_low();
        spi_byte(8'hAB, 5, 1'b0, r0);
        ss_high();
        chk("abort_rd", rd_data, 32'h081);
        chk("abort_miso", {31'd0, spi_miso}, 32'h1);
        ss_low();
        spi_byte(8'h55, 8, 1'b0, r0);
        ss_high();
        chk("after_abort_rx", {24'd0, r0}, 32'hFF);
        chk("after_abort_rd", rd_data, 32'h155);

        // pop coincident with completion of the second byte
        bus_wr(5'd2, 32'h3);
        chk("pop_rd", rd_data, 32'h055);
        ss_low();
        spi_byte(8'h11, 8, 1'b0, r0);
        spi_byte(8'h99, 8, 1'b1, r1);
        ss_high();
        chk("coinc_rd", rd_data, 32'h199);

        // reset in the middle of a frame
        bus_wr(5'd2, 32'h3);
        bus_wr(5'd1, 32'h3C);
        ss_low();
        spi_byte(8'hF0, 4, 1'b0, r0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_rd", rd_data, 32'h0);
        chk("midrst_miso_en", {31'd0, spi_miso_en}, 32'h0);
        chk("midrst_miso", {31'd0, spi_miso}, 32'h1);
        ss_high();
        ss_low();
        chk("dis_miso_en", {31'd0, spi_miso_en}, 32'h0);
        spi_byte(8'hA5, 8, 1'b0, r0);
        ss_high();
        chk("dis_master_rx", {24'd0, r0}, 32'hFF);
        chk("dis_rd", rd_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chu_spi_slave_core.md
# chu_spi_slave_core

MMIO slot core that acts as an SPI peripheral (slave). An external SPI master drives it: it receives 8-bit frames on `spi_mosi` and returns CPU-supplied bytes on `spi_miso`. It supports all four CPOL/CPHA modes and sits on the same slot bus as the SPI master core. It lets the processor talk to an off-board SPI master, such as a second FPGA or a test MCU.

## Interface
- No parameters (single SS input, 8-bit frames, MSB first).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cs`  in  1  slot select.
- `read`  in  1  slot read strobe; unused, reads have no side effects.
- `write`  in  1  slot write strobe.
- `addr`  in  5  register address; only `addr[1:0]` decoded.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  `{20'b0, ss_active, overrun, tx_full, rx_valid, rx_data[7:0]}`, combinational and address-independent.
- `spi_sclk`  in  1  external serial clock (asynchronous).
- `spi_mosi`  in  1  external serial data in (asynchronous).
- `spi_ss_n`  in  1  external select, active low (asynchronous).
- `spi_miso`  out  1  serial data out, equal to `tx_shreg[7]`.
- `spi_miso_en`  out  1  tristate enable for the top-level buffer; equals `ss_active & enable`.

## Operation
- **Register writes** (`cs & write`):
  - addr 01 loads `tx_buf <= wr_data[7:0]` and sets `tx_full = 1`.
  - addr 10: `wr_data[0]` clears `rx_valid` (pop); `wr_data[1]` clears `overrun`.
  - addr 11 writes `ctrl <= wr_data[2:0]`, where bit0 = cpol, bit1 = cpha, bit2 = enable.
  - addr 00 write is ignored.
- **Synchronizers:** `spi_sclk`, `spi_mosi` and `spi_ss_n` each pass through a 2-FF synchronizer. `sclk` gets a third register for edge detection. `mosi` is delayed equally, so it stays aligned with `sclk`.
- **Edge definitions:**
  - `ss_active` = synchronized `ss_n` low AND enable.
  - Leading edge = rise if the active cpol is 0, fall if it is 1. Trailing edge = the opposite.
  - cpol and cpha are copied into active registers on the `ss_active` 0→1 transition. Ctrl writes mid-frame do not affect the current frame.
- **Frame start** (`ss_active` rises): `bit_cnt <= 0`. If cpha = 0, load `tx_shreg` (see load rule).
- **Load rule:** if `tx_full`, then `tx_shreg <= tx_buf` and `tx_full <= 0`; otherwise `tx_shreg <= 8'hFF`.
- **cpha = 0:**
  - Leading edge samples: `rx_shreg <= {rx_shreg[6:0], mosi}`, `bit_cnt++` (mod 8).
  - Trailing edge: if `bit_cnt == 0`, apply the load rule; else `tx_shreg <<= 1`.
- **cpha = 1:**
  - Leading edge: if `bit_cnt == 0`, apply the load rule; else `tx_shreg <<= 1`.
  - Trailing edge samples and increments `bit_cnt`.
- **Byte completion:** the sample that takes `bit_cnt` from 7 to 0 writes `rx_data <= {rx_shreg[6:0], mosi}` and sets `rx_valid = 1`.
  - If `rx_valid` was already 1 and is not popped in the same cycle, set `overrun = 1`. New data overwrites old.
- **Back-to-back bytes:** multiple bytes per `ss_n` low period are supported; `bit_cnt` wraps.
- **Frame end** (`ss_active` falls, including mid-byte):
  - `bit_cnt <= 0`; partial rx bits are discarded.
  - `rx_valid`, `rx_data`, `overrun` and `tx_full` are unchanged.
  - `tx_shreg <= 8'hFF`.
- **Enable = 0:** the frame engine is held idle (`ss_active = 0`); register writes still work.

## Timing
- **Reset values:** `rx_data = 0`, `rx_valid = 0`, `tx_full = 0`, `overrun = 0`, `ctrl = 0`, `tx_buf = 0`, `tx_shreg = 8'hFF`, `bit_cnt = 0`. Outputs: `spi_miso = 1`, `spi_miso_en = 0`, `rd_data = 0`.
  - Synchronizers reset as follows: `ss_n` stages to 1, `sclk`/`mosi` stages to 0.
  - Reset mid-frame aborts the frame. The frame engine restarts only on the next `ss_active` rise after enable is rewritten to 1.
- **Input latency:** a pin edge is seen as an edge pulse 3 `clk` cycles later. The sample or shift takes effect on the following cycle.
- **Byte status:** `rx_valid`/`rx_data` are visible on `rd_data` 1 cycle after the 8th sample pulse.
- **MISO latency:** `spi_miso` changes at most 4 `clk` cycles after the driving external `sclk` edge.
- **Clock requirements:** `sclk` high and low times ≥ 4 `clk` periods (`sclk ≤ clk/8`). For cpha = 0, the master waits ≥ 5 `clk` between `ss_n` fall and the first `sclk` edge.
- **Simultaneous events:**
  - Pop with byte completion: completion wins; `rx_valid` stays 1 and `overrun` is not set.
  - Overrun clear with overrun set: set wins.
  - `tx_buf` write with load: the load takes the old `tx_buf`, and the write leaves `tx_full = 1` with new data.

## Test plan
- **Mode 0 single byte:** `ctrl = 3'b100`, `tx_buf = 0xA5`, master sends 0x3C at `clk/8` → `rx_data = 0x3C`, `rx_valid = 1`, `tx_full = 0`, master receives 0xA5.
- **Mode 3:** `ctrl = 3'b111`, `tx_buf = 0x5A`, master sends 0xC3 → `rx_data = 0xC3`, master receives 0x5A. Repeat for modes 1 and 2.
- **Two bytes in one `ss_n` frame, no pop:** master sends 0x12 then 0x81 with `tx_buf` loaded once with 0x77 → master receives 0x77 then 0xFF; `rx_data = 0x81`, `overrun = 1`. Then write addr 10 with 0x3 → `rx_valid = 0`, `overrun = 0`.
- **Aborted byte:** `ss_n` high after 5 bits → `rx_valid` stays 0. Next full frame 0x55 → `rx_data = 0x55`.
- **Coincident pop and completion:** pop lands in the same cycle as the completion of a second byte 0x99 → `rx_valid = 1`, `overrun = 0`, `rx_data = 0x99`.
- **Reset mid-frame after 4 bits** → `rd_data = 0`, `spi_miso_en = 0`, `spi_miso = 1`. With enable = 0, a subsequent frame is ignored.
